// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch-to-decode prefetch queue (package fetch_pkg).
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INST = 32'h00000000;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch (producer), the prefetch queue, and decode (consumer).
interface fetch_queue_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_next_pc;
    logic [31:0] in_inst;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_next_pc;
    logic [31:0] out_inst;

    modport master (
        output in_valid, in_pc, in_next_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_next_pc, out_inst
    );

    modport slave (
        input  in_valid, in_pc, in_next_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_next_pc, out_inst
    );

endinterface

// File: rtl/fetch_queue_ctrl.sv
// Pointer, occupancy and handshake qualification for fetch_queue.
// FETCH_QUEUE_BYPASS_EN enables zero-latency pass-through when the queue is empty.
module fetch_queue_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             bypass,
    output logic             push,
    output logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);

    logic empty;

    assign empty    = (count == '0);
    assign in_ready = (count != FULL_COUNT);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed triple taken by decode in the same cycle never touches storage.
    assign out_valid = !empty || bypass;
    assign push      = in_valid && in_ready && !flush && !(bypass && out_ready);
    assign pop       = !empty && out_ready && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode; flush discards everything on a taken branch.
// Optional zero-latency empty bypass under FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    fetch_queue_if.slave   bus,
    output logic [PTR_W:0] count
);

    fetch_entry_t     mem [DEPTH];
    fetch_entry_t     head;
    fetch_entry_t     incoming;
    logic             in_ready;
    logic             out_valid;
    logic             bypass;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    fetch_queue_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .bypass    (bypass),
        .push      (push),
        .pop       (pop),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    assign incoming = '{pc: bus.in_pc, next_pc: bus.in_next_pc, inst: bus.in_inst};

    // Storage is deliberately not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= incoming;
    end

    always_comb begin
        head = '{pc: 32'h0, next_pc: 32'h0, inst: NOP_INST};
        if (bypass)         head = incoming;
        else if (out_valid) head = mem[rd_ptr];
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_pc      = head.pc;
    assign bus.out_next_pc = head.next_pc;
    assign bus.out_inst    = head.inst;

    // pop is consumed only through the pointer update in the controller.
    logic unused_pop;
    assign unused_pop = pop;

endmodule
